seq_divider: RTL

//  Signed sequential integer divider; inverse companion to the combinational multiplier (x*y -> product).

---
 rtl/arith_pkg.sv | 17 +
 rtl/seq_divider_step.sv | 27 ++
 rtl/seq_divider.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: default operand width, divider FSM states,
// and the two's-complement edge constants used by the multiplier and divider benches.
package arith_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] MIN_INT  = {1'b1, {(DIV_WIDTH-1){1'b0}}};
    localparam logic [DIV_WIDTH-1:0] ALL_ONES = {DIV_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } div_state_e;

endpackage

// File: rtl/seq_divider_step.sv
// One radix-2 restoring step on magnitudes: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference if it fits.
module div_step
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;

    // The shifted remainder needs one extra bit; once the divisor is subtracted
    // (or when it is not) the result is below the divisor and fits in WIDTH bits.
    always_comb begin
        shifted = {rem_in, bit_in};
        trial   = shifted[WIDTH-1:0] - divisor;
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? trial : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Signed sequential divider: one restoring step per clock on operand magnitudes,
// then a sign-fix cycle that registers truncating quotient/remainder and flags.
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] mag_y_q, mag_y_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_pend_q, dbz_pend_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic             accept;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in (rem_q),
        .bit_in (dvd_q[WIDTH-1]),
        .divisor(mag_y_q),
        .rem_out(step_rem),
        .q_bit  (step_q)
    );

    // Quotient bits are shifted into the bottom of the dividend register, so after
    // WIDTH steps it holds the quotient magnitude. Negating MIN_INT yields the
    // unsigned value 2^(WIDTH-1), which is exactly the magnitude we need.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        dvd_d         = dvd_q;
        rem_d         = rem_q;
        mag_y_d       = mag_y_q;
        x_d           = x_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        dbz_pend_d    = dbz_pend_q;
        ovf_pend_d    = ovf_pend_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;
        accept        = 1'b0;

        case (state_q)
            S_IDLE: accept = start;
            S_CALC: begin
                dvd_d   = {dvd_q[WIDTH-2:0], step_q};
                rem_d   = step_rem;
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quotient_d    = dbz_pend_q ? {WIDTH{1'b1}} : (neg_quo_q ? -dvd_q : dvd_q);
                remainder_d   = dbz_pend_q ? x_q : (neg_rem_q ? -rem_q : rem_q);
                div_by_zero_d = dbz_pend_q;
                overflow_d    = ovf_pend_q;
                state_d       = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                accept  = start;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            state_d    = S_CALC;
            count_d    = '0;
            dvd_d      = x[WIDTH-1] ? -x : x;
            rem_d      = '0;
            mag_y_d    = y[WIDTH-1] ? -y : y;
            x_d        = x;
            neg_quo_d  = x[WIDTH-1] ^ y[WIDTH-1];
            neg_rem_d  = x[WIDTH-1];
            dbz_pend_d = (y == '0);
            ovf_pend_d = (x == MIN_VAL) && (y == {WIDTH{1'b1}});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            dvd_q         <= '0;
            rem_q         <= '0;
            mag_y_q       <= '0;
            x_q           <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_pend_q    <= 1'b0;
            ovf_pend_q    <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            dvd_q         <= dvd_d;
            rem_q         <= rem_d;
            mag_y_q       <= mag_y_d;
            x_q           <= x_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            dbz_pend_q    <= dbz_pend_d;
            ovf_pend_q    <= ovf_pend_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
        end
    end

    assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
    assign done        = (state_q == S_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign overflow    = overflow_q;

endmodule
